conv2d_2_bram_reader: RTL and testbench
=======================================

// Module: conv2d_2_bram_reader
// PURPOSE
//  Port-B initiator for the Conv2D_2 dual-port block RAM (1 clock, 32-bit words, 4-bit byte we).
//  On a start command, reads LEN consecutive words from a byte base address.
//  Streams the words to the Conv2D_2 datapath over a valid/ready interface, with backpressure and a last flag.
//  Never writes: BRAM port B is read-only from this block; port A stays with the loader.
// PARAMETERS
//  READ_LAT    1   BRAM read latency in cycles, from en sampled to dout valid (1 or 2)
//  FIFO_DEPTH  4   output buffer depth; must be >= READ_LAT+2 for 1 word/cycle
//  LEN_W       16  width of the word-count field
// PORTS
//  clk                input   1      system clock; also drives BRAM_PORTB_0_clk
//  rst                input   1      synchronous, active-high reset
//  start              input   1      command strobe; sampled only when busy=0
//  base_addr          input   32     byte address of the first word (bits[1:0] ignored, forced 0)
//  len                input   LEN_W  number of 32-bit words to read
//  busy               output  1      command in progress
//  done               output  1      1-cycle pulse when the command completes
//  m_data             output  32     stream data
//  m_valid            output  1      stream valid
//  m_ready            input   1      stream ready
//  m_last             output  1      marks the final word of the command
//  BRAM_PORTB_0_addr  output  32     BRAM byte address, registered
//  BRAM_PORTB_0_clk   output  1      equals clk
//  BRAM_PORTB_0_din   output  32     constant 0
//  BRAM_PORTB_0_dout  input   32     BRAM read data
//  BRAM_PORTB_0_en    output  1      read enable, registered
//  BRAM_PORTB_0_we    output  4      constant 4'b0000
// BEHAVIOUR
//  Reset values: busy=0, done=0, m_valid=0, m_last=0, m_data=0, en=0, addr=0.
//   Reset also clears the FIFO, all counters and all in-flight tags.
//   Reset mid-command abandons the command: no done pulse, late dout is discarded.
//  FSM states: IDLE -> ISSUE -> DRAIN -> IDLE.
//   IDLE: start=1 latches addr=base_addr&~3 and issue_cnt=len, sets busy=1.
//    If len=0, pulses done on the next cycle and stays in IDLE. Otherwise goes to ISSUE.
//   ISSUE: drives en=1 with the current addr only when credit is available.
//    Credit condition: inflight + fifo_count (+1 if popping this cycle) < FIFO_DEPTH.
//    Each issued read: addr += 4, wrapping mod 2^32; issue_cnt -= 1.
//    When the last read is issued, goes to DRAIN.
//   DRAIN: waits until the final word is handshaked (m_valid & m_ready & m_last).
//    Then pulses done for 1 cycle, drops busy in that same cycle, and returns to IDLE.
//  Read return: a READ_LAT-deep shift register of valid bits tracks each en.
//   When a tag emerges, BRAM_PORTB_0_dout is pushed into the FIFO with its last flag.
//   The FIFO never overflows, because credits guarantee space.
//  Stream handshake:
//   m_data, m_last and m_valid come from the FIFO head.
//   A word transfers when m_valid & m_ready.
//   m_data and m_last stay stable while m_valid=1 and m_ready=0.
//   Simultaneous push and pop in one cycle are both honoured.
//  Latency: with start in cycle 0, en=1 in cycle 1 and m_valid=1 in cycle 2+READ_LAT.
//   With m_ready held at 1, the block sustains 1 word per cycle.
//  start while busy=1 is ignored. base_addr and len are sampled only at accept.
//  The block never asserts we or drives non-zero din.
// TESTING
//  1. len=4, base=0x100, m_ready=1, BRAM[i]=i:
//     -> addr 0x100,0x104,0x108,0x10C on consecutive cycles; data 0x40..0x43.
//     -> m_last on the 4th word; done 1 cycle after it.
//  2. len=16, m_ready toggling 1010, READ_LAT=2:
//     -> all 16 words in order, no loss or duplicates; en stalls when credits run out.
//  3. len=0 -> done pulses in cycle 1; en never asserted; m_valid stays 0.
//  4. base=0xFFFFFFF8, len=4 -> addr 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
//  5. A second start while busy -> ignored; exactly one done for the first command.
//  6. rst after 3 words issued -> all outputs 0 next cycle, no done.
//     A new len=2 command afterwards returns only its own 2 words.

Source files
------------

// File: rtl/conv2d_2_bram_reader.sv
// conv2d_2_bram_reader
//   Read-only port-B initiator for the Conv2D_2 dual-port block RAM. A start
//   command reads len consecutive 32-bit words beginning at a byte base address
//   and streams them out over valid/ready with a last flag. Reads are issued
//   only when the output FIFO is guaranteed to have room for the returning
//   word, so the FIFO can never overflow.
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   start/base_addr/len : command (sampled only while busy=0)
//   busy, done          : command in progress, 1-cycle completion pulse
//   m_data/m_valid/m_ready/m_last : output word stream
//   BRAM_PORTB_0_*      : BRAM port B (registered en/addr, we/din tied to 0)
module conv2d_2_bram_reader #(
   parameter int READ_LAT   = 1,
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      base_addr,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic [31:0]      m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_last,
   output logic [31:0]      BRAM_PORTB_0_addr,
   output logic             BRAM_PORTB_0_clk,
   output logic [31:0]      BRAM_PORTB_0_din,
   input  logic [31:0]      BRAM_PORTB_0_dout,
   output logic             BRAM_PORTB_0_en,
   output logic [3:0]       BRAM_PORTB_0_we
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + READ_LAT + 2) + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t             state_q;
   logic               busy_q, done_q, en_q, en_last_q;
   logic [31:0]        addr_q, next_addr_q;
   logic [LEN_W-1:0]   issue_cnt_q;          // reads still to be issued
   logic [READ_LAT-1:0] tag_q, tag_last_q;   // one bit per read in flight inside the BRAM
   logic [32:0]        mem_q [FIFO_DEPTH];   // {last, data}
   logic [PW-1:0]      wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic [CW-1:0]      inflight;
   logic               push, pop, credit;

   assign BRAM_PORTB_0_clk  = clk;
   assign BRAM_PORTB_0_din  = 32'h0000_0000;
   assign BRAM_PORTB_0_we   = 4'b0000;
   assign BRAM_PORTB_0_en   = en_q;
   assign BRAM_PORTB_0_addr = addr_q;
   assign busy              = busy_q;
   assign done              = done_q;
   assign m_valid           = (count_q != {CW{1'b0}});
   assign m_data            = m_valid ? mem_q[rd_ptr_q][31:0] : 32'h0000_0000;
   assign m_last            = m_valid & mem_q[rd_ptr_q][32];

   // Credit: words already owed to the FIFO (on en or in the BRAM pipe) plus
   // words stored must leave room for one more, counting a pop this cycle.
   always_comb begin
      inflight = CW'(en_q);
      for (int i = 0; i < READ_LAT; i++) begin
         inflight = inflight + CW'(tag_q[i]);
      end
      push     = tag_q[READ_LAT-1];
      pop      = m_valid & m_ready;
      credit   = (inflight + count_q) < (CW'(FIFO_DEPTH) + CW'(pop));
      count_d  = count_q + CW'(push) - CW'(pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? {PW{1'b0}} : wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? {PW{1'b0}} : rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // Command FSM; en/addr are registered so the first read appears the cycle after start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         en_q        <= 1'b0;
         en_last_q   <= 1'b0;
         addr_q      <= 32'h0000_0000;
         next_addr_q <= 32'h0000_0000;
         issue_cnt_q <= {LEN_W{1'b0}};
      end else begin
         done_q    <= 1'b0;
         en_q      <= 1'b0;
         en_last_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // FIFO and BRAM pipe are always empty here, so the first read needs no credit check.
               if (start) begin
                  if (len == {LEN_W{1'b0}}) begin
                     done_q <= 1'b1;
                  end else begin
                     busy_q      <= 1'b1;
                     en_q        <= 1'b1;
                     addr_q      <= base_addr & 32'hFFFF_FFFC;
                     next_addr_q <= (base_addr & 32'hFFFF_FFFC) + 32'd4;
                     issue_cnt_q <= len - LEN_W'(1);
                     if (len == LEN_W'(1)) begin
                        en_last_q <= 1'b1;
                        state_q   <= S_DRAIN;
                     end else begin
                        state_q   <= S_ISSUE;
                     end
                  end
               end
            end
            S_ISSUE: begin
               if (credit) begin
                  en_q        <= 1'b1;
                  addr_q      <= next_addr_q;
                  next_addr_q <= next_addr_q + 32'd4;
                  issue_cnt_q <= issue_cnt_q - LEN_W'(1);
                  if (issue_cnt_q == LEN_W'(1)) begin
                     en_last_q <= 1'b1;
                     state_q   <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (pop && m_last) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Tag pipe: mirrors the BRAM read latency so dout is captured exactly when valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_q      <= {READ_LAT{1'b0}};
         tag_last_q <= {READ_LAT{1'b0}};
      end else begin
         tag_q[0]      <= en_q;
         tag_last_q[0] <= en_last_q;
         for (int i = 1; i < READ_LAT; i++) begin
            tag_q[i]      <= tag_q[i-1];
            tag_last_q[i] <= tag_last_q[i-1];
         end
      end
   end

   // Output FIFO; push and pop in the same cycle are both applied.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 33'h0_0000_0000;
         end
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= {tag_last_q[READ_LAT-1], BRAM_PORTB_0_dout};
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_conv2d_2_bram_reader.sv
module tb_conv2d_2_bram_reader;
   localparam int READ_LAT   = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int LEN_W      = 16;

   logic             clk = 1'b0;
   logic             rst, start, m_ready;
   logic [31:0]      base_addr;
   logic [LEN_W-1:0] len;
   logic             busy, done, m_valid, m_last;
   logic [31:0]      m_data;
   logic [31:0]      bram_addr, bram_din, bram_dout;
   logic             bram_clk, bram_en;
   logic [3:0]       bram_we;

   int total = 0;
   int bad   = 0;

   conv2d_2_bram_reader #(
      .READ_LAT(READ_LAT), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
      .busy(busy), .done(done), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .m_last(m_last),
      .BRAM_PORTB_0_addr(bram_addr), .BRAM_PORTB_0_clk(bram_clk),
      .BRAM_PORTB_0_din(bram_din), .BRAM_PORTB_0_dout(bram_dout),
      .BRAM_PORTB_0_en(bram_en), .BRAM_PORTB_0_we(bram_we)
   );

   always #5 clk = ~clk;

   // BRAM model: word at byte address a holds a/4; read latency READ_LAT cycles.
   logic [31:0] pa [READ_LAT];
   always @(posedge clk) begin
      if (bram_en) pa[0] <= bram_addr;
      for (int i = 1; i < READ_LAT; i++) pa[i] <= pa[i-1];
   end
   assign bram_dout = {2'b00, pa[READ_LAT-1][31:2]};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one command and follow it to its done pulse. mode 0: ready=1, mode 1: ready 1010.
   task automatic run_cmd(input logic [31:0] base, input int n, input int mode, input int dup_at);
      logic [31:0] b, a, pd;
      logic        pl;
      int ne, nw, last_hs, first_v, first_en, last_en, extra;
      bit stall_seen, prev_stall, got_done;
      b = base & 32'hFFFF_FFFC;
      ne = 0; nw = 0; last_hs = -10; first_v = -1; first_en = 0; last_en = 0;
      stall_seen = 0; prev_stall = 0; got_done = 0; pd = 32'h0; pl = 1'b0;
      start = 1'b1; base_addr = base; len = LEN_W'(n); m_ready = 1'b1;
      tick();
      start = 1'b0;
      check("en_in_cycle1", 32'(bram_en), 32'd1);
      check("busy_in_cycle1", 32'(busy), 32'd1);
      check("we_zero", 32'(bram_we), 32'd0);
      check("din_zero", bram_din, 32'd0);
      for (int t = 1; t < 400; t++) begin
         if (t == dup_at) begin
            start = 1'b1; base_addr = 32'h0000_0800; len = 16'd5;
         end else begin
            start = 1'b0;
         end
         m_ready = (mode == 1) ? ((t % 2) == 1) : 1'b1;
         if (prev_stall) begin
            check("hold_valid", 32'(m_valid), 32'd1);
            check("hold_data", m_data, pd);
            check("hold_last", 32'(m_last), 32'(pl));
         end
         if (bram_en) begin
            a = b + 32'(4 * ne);
            check("addr", bram_addr, a);
            if (ne == 0) first_en = t;
            else if (t != last_en + 1) stall_seen = 1;
            last_en = t;
            ne++;
         end
         if (m_valid && first_v < 0) first_v = t;
         if (done) begin
            got_done = 1;
            check("done_after_last", 32'(t), 32'(last_hs + 1));
            check("busy_low_at_done", 32'(busy), 32'd0);
            break;
         end
         if (m_valid && m_ready) begin
            a = b + 32'(4 * nw);
            check("data", m_data, {2'b00, a[31:2]});
            check("last", 32'(m_last), 32'(nw == n - 1));
            last_hs = t;
            nw++;
         end
         prev_stall = m_valid & ~m_ready;
         pd = m_data;
         pl = m_last;
         tick();
      end
      start = 1'b0;
      check("done_seen", 32'(got_done), 32'd1);
      check("word_count", 32'(nw), 32'(n));
      check("read_count", 32'(ne), 32'(n));
      check("first_valid_cycle", 32'(first_v), 32'(2 + READ_LAT));
      if (mode == 0) check("back_to_back_en", 32'(last_en - first_en), 32'(n - 1));
      else           check("en_stalled", 32'(stall_seen), 32'd1);
      extra = 0;
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done || bram_en || m_valid || busy) extra++;
      end
      check("quiet_after_done", 32'(extra), 32'd0);
   endtask

   initial begin
      int ne, extra;
      rst = 1'b1; start = 1'b0; m_ready = 1'b0; base_addr = 32'h0; len = '0;
      tick(); tick(); tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_valid", 32'(m_valid), 32'd0);
      check("rst_last", 32'(m_last), 32'd0);
      check("rst_data", m_data, 32'd0);
      check("rst_en", 32'(bram_en), 32'd0);
      check("rst_addr", bram_addr, 32'd0);
      rst = 1'b0;
      tick();

      // 1: len=4 from 0x100, full rate
      run_cmd(32'h0000_0100, 4, 0, -1);
      // 2: len=16, ready toggling -> credit stalls
      run_cmd(32'h0000_0400, 16, 1, -1);

      // 3: len=0 -> done in cycle 1, nothing else
      start = 1'b1; base_addr = 32'h0000_0500; len = 16'd0; m_ready = 1'b1;
      tick();
      start = 1'b0;
      check("len0_done", 32'(done), 32'd1);
      check("len0_en", 32'(bram_en), 32'd0);
      check("len0_valid", 32'(m_valid), 32'd0);
      tick();
      check("len0_done_pulse", 32'(done), 32'd0);
      check("len0_en2", 32'(bram_en), 32'd0);
      check("len0_valid2", 32'(m_valid), 32'd0);
      tick();

      // 4: address wrap
      run_cmd(32'hFFFF_FFF8, 4, 0, -1);
      // 5: second start while busy, unaligned base (low bits ignored)
      run_cmd(32'h0000_0203, 6, 0, 3);

      // 6: reset after 3 reads issued
      start = 1'b1; base_addr = 32'h0000_0200; len = 16'd8; m_ready = 1'b0;
      tick();
      start = 1'b0;
      ne = 0;
      for (int t = 1; t < 20; t++) begin
         if (bram_en) ne++;
         if (ne == 3) break;
         tick();
      end
      check("rst6_three_issued", 32'(ne), 32'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst6_busy", 32'(busy), 32'd0);
      check("rst6_done", 32'(done), 32'd0);
      check("rst6_valid", 32'(m_valid), 32'd0);
      check("rst6_last", 32'(m_last), 32'd0);
      check("rst6_data", m_data, 32'd0);
      check("rst6_en", 32'(bram_en), 32'd0);
      check("rst6_addr", bram_addr, 32'd0);
      m_ready = 1'b1;
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done || bram_en || m_valid || busy) extra++;
      end
      check("rst6_no_late_words", 32'(extra), 32'd0);
      run_cmd(32'h0000_0300, 2, 0, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
